// File: rtl/ebox_mem_req_queue.sv
// EBOX memory request queue: DEPTH-entry FIFO that issues its head to MBOX, reissues on retry, completes in order.
// Completion/abort pulses one cycle after mboxResp/final mboxRetry; reqReady drops only when all DEPTH entries are held.
module ebox_mem_req_queue #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 36,
    parameter int MAX_RETRY = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic [ADDR_W-1:0]          reqVMA,
    input  logic [1:0]                 reqOp,
    input  logic [DATA_W-1:0]          reqData,
    output logic                       mboxReq,
    output logic [ADDR_W-1:0]          mboxVMA,
    output logic [1:0]                 mboxOp,
    output logic [DATA_W-1:0]          mboxWrData,
    input  logic                       mboxT0,
    input  logic                       mboxRetry,
    input  logic                       mboxResp,
    input  logic [DATA_W-1:0]          mboxRdData,
    output logic                       respValid,
    output logic [DATA_W-1:0]          respData,
    output logic [1:0]                 respOp,
    output logic                       retryErr,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [7:0]       MAX_RETRY_C = 8'(MAX_RETRY);
    localparam logic [OCC_W-1:0] FULL_C      = OCC_W'(DEPTH);
    localparam logic [1:0]       OP_WRITE    = 2'b01;

    typedef struct packed {
        logic [ADDR_W-1:0] vma;
        logic [1:0]        op;
        logic [DATA_W-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    state_t             state_q, state_d;
    logic [7:0]         retry_q, retry_d;
    logic               resp_vld_q, resp_vld_d;
    logic [DATA_W-1:0]  resp_dat_q, resp_dat_d;
    logic [1:0]         resp_op_q, resp_op_d;
    logic               retry_err_q, retry_err_d;

    logic   push;
    logic   pop_done;
    logic   pop_abort;
    logic   pop;
    logic   empty;
    entry_t head_ent;

    assign empty    = (occ_q == '0);
    assign reqReady = (occ_q != FULL_C);
    assign push     = reqValid && reqReady;
    assign pop      = pop_done || pop_abort;
    assign head_ent = mem_q[head_q];

    // Outputs mirror the head entry and read as zero when nothing is queued.
    assign mboxVMA    = empty ? '0 : head_ent.vma;
    assign mboxOp     = empty ? '0 : head_ent.op;
    assign mboxWrData = empty ? '0 : head_ent.dat;

    assign respValid = resp_vld_q;
    assign respData  = resp_dat_q;
    assign respOp    = resp_op_q;
    assign retryErr  = retry_err_q;
    assign occupancy = occ_q;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        pop_done  = 1'b0;
        pop_abort = 1'b0;
        mboxReq   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_ISSUE;
                    retry_d = '0;
                end
            end
            S_ISSUE: begin
                mboxReq = 1'b1;
                if (mboxT0) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the same cycle as a retry completes the reference.
                if (mboxResp) begin
                    pop_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (mboxRetry) begin
                    if (retry_q == MAX_RETRY_C) begin
                        pop_abort = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d      = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d      = push ? tail_q + PTR_W'(1) : tail_q;
        occ_d       = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        resp_vld_d  = pop_done;
        retry_err_d = pop_abort;
        resp_op_d   = resp_op_q;
        resp_dat_d  = resp_dat_q;
        if (pop_done) begin
            resp_op_d  = head_ent.op;
            resp_dat_d = (head_ent.op == OP_WRITE) ? '0 : mboxRdData;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{vma: reqVMA, op: reqOp, dat: reqData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            state_q     <= S_IDLE;
            retry_q     <= '0;
            resp_vld_q  <= 1'b0;
            resp_dat_q  <= '0;
            resp_op_q   <= '0;
            retry_err_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            state_q     <= state_d;
            retry_q     <= retry_d;
            resp_vld_q  <= resp_vld_d;
            resp_dat_q  <= resp_dat_d;
            resp_op_q   <= resp_op_d;
            retry_err_q <= retry_err_d;
        end
    end

endmodule

// File: tb/tb_ebox_mem_req_queue.sv
// Directed bench for ebox_mem_req_queue (DEPTH=4, MAX_RETRY=7); inputs change and outputs are sampled 1ns after posedge.
module tb_ebox_mem_req_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [22:0] reqVMA;
    logic [1:0]  reqOp;
    logic [35:0] reqData;
    logic        mboxReq;
    logic [22:0] mboxVMA;
    logic [1:0]  mboxOp;
    logic [35:0] mboxWrData;
    logic        mboxT0;
    logic        mboxRetry;
    logic        mboxResp;
    logic [35:0] mboxRdData;
    logic        respValid;
    logic [35:0] respData;
    logic [1:0]  respOp;
    logic        retryErr;
    logic [2:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    ebox_mem_req_queue #(.DEPTH(4), .ADDR_W(23), .DATA_W(36), .MAX_RETRY(7)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqVMA(reqVMA), .reqOp(reqOp), .reqData(reqData),
        .mboxReq(mboxReq), .mboxVMA(mboxVMA), .mboxOp(mboxOp), .mboxWrData(mboxWrData),
        .mboxT0(mboxT0), .mboxRetry(mboxRetry), .mboxResp(mboxResp), .mboxRdData(mboxRdData),
        .respValid(respValid), .respData(respData), .respOp(respOp), .retryErr(retryErr),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; reqValid = 1'b0; reqVMA = '0; reqOp = '0; reqData = '0;
        mboxT0 = 1'b0; mboxRetry = 1'b0; mboxResp = 1'b0; mboxRdData = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [22:0] vma, input logic [1:0] op, input logic [35:0] dat);
        reqValid = 1'b1; reqVMA = vma; reqOp = op; reqData = dat;
        tick();
        reqValid = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mboxReq) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) ok = mboxReq;
    endtask

    task automatic pulse_t0();
        mboxT0 = 1'b1; tick(); mboxT0 = 1'b0;
    endtask

    task automatic pulse_retry();
        mboxRetry = 1'b1; tick(); mboxRetry = 1'b0;
    endtask

    task automatic pulse_resp(input logic [35:0] dat);
        mboxResp = 1'b1; mboxRdData = dat; tick(); mboxResp = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (occupancy !== 3'd0 || reqReady !== 1'b1 || mboxReq !== 1'b0 || respValid !== 1'b0 || retryErr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: occ=%0d rdy=%b req=%b rv=%b err=%b required 0 1 0 0 0", occupancy, reqReady, mboxReq, respValid, retryErr);
        end
        checks++;
        if (respData !== '0 || respOp !== 2'd0 || mboxVMA !== '0 || mboxOp !== 2'd0 || mboxWrData !== '0) begin
            failures++;
            $display("FAIL reset_data: rd=%0h rop=%0d vma=%0h op=%0d wd=%0h required all 0", respData, respOp, mboxVMA, mboxOp, mboxWrData);
        end
    endtask

    task automatic test_single_read();
        bit ok;
        do_reset();
        push(23'h000123, 2'b00, 36'h0);
        checks++;
        if (occupancy !== 3'd1 || mboxReq !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_push: occ=%0d req=%b required 1 0", occupancy, mboxReq);
        end
        tick();
        checks++;
        if (mboxReq !== 1'b1 || mboxVMA !== 23'h000123 || mboxOp !== 2'b00) begin
            failures++;
            $display("FAIL rd_issue: req=%b vma=%0h op=%0d required 1 123 0", mboxReq, mboxVMA, mboxOp);
        end
        pulse_t0();
        checks++;
        if (mboxReq !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait_req: got %b required 0", mboxReq);
        end
        tick();
        pulse_resp(36'o123456701234);
        checks++;
        if (respValid !== 1'b1 || respData !== 36'o123456701234 || respOp !== 2'b00 || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL rd_resp: rv=%b data=%0o op=%0d occ=%0d required 1 123456701234 0 0", respValid, respData, respOp, occupancy);
        end
        tick();
        checks++;
        if (respValid !== 1'b0 || mboxReq !== 1'b0) begin
            failures++;
            $display("FAIL rd_pulse_end: rv=%b req=%b required 0 0", respValid, mboxReq);
        end
        ok = 1'b0;
    endtask

    task automatic test_fill();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) push(23'h10 + 23'(i), 2'b01, 36'hA0 + 36'(i));
        checks++;
        if (occupancy !== 3'd4 || reqReady !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: occ=%0d rdy=%b required 4 0", occupancy, reqReady);
        end
        push(23'h1F, 2'b01, 36'hFF);
        checks++;
        if (occupancy !== 3'd4) begin
            failures++;
            $display("FAIL fill_5th_push: occ=%0d required 4", occupancy);
        end
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            checks++;
            if (!ok || mboxVMA !== 23'h10 + 23'(i) || mboxWrData !== 36'hA0 + 36'(i) || mboxOp !== 2'b01) begin
                failures++;
                $display("FAIL fill_issue%0d: req=%b vma=%0h wd=%0h op=%0d required 1 %0h %0h 1", i, ok, mboxVMA, mboxWrData, mboxOp, 23'h10 + 23'(i), 36'hA0 + 36'(i));
            end
            pulse_t0();
            pulse_resp(36'hFFF);
            checks++;
            if (respValid !== 1'b1 || respData !== '0 || respOp !== 2'b01 || occupancy !== 3'(3 - i)) begin
                failures++;
                $display("FAIL fill_resp%0d: rv=%b data=%0h op=%0d occ=%0d required 1 0 1 %0d", i, respValid, respData, respOp, occupancy, 3 - i);
            end
        end
        tick();
        checks++;
        if (respValid !== 1'b0 || occupancy !== 3'd0 || mboxVMA !== '0 || reqReady !== 1'b1) begin
            failures++;
            $display("FAIL fill_drained: rv=%b occ=%0d vma=%0h rdy=%b required 0 0 0 1", respValid, occupancy, mboxVMA, reqReady);
        end
    endtask

    task automatic test_retry();
        bit ok;
        do_reset();
        push(23'h200, 2'b00, 36'h0);
        wait_req(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL retry_first_issue: req=0 required 1");
        end
        pulse_t0();
        pulse_retry();
        checks++;
        if (mboxReq !== 1'b1 || retryErr !== 1'b0 || respValid !== 1'b0 || occupancy !== 3'd1) begin
            failures++;
            $display("FAIL retry_reissue: req=%b err=%b rv=%b occ=%0d required 1 0 0 1", mboxReq, retryErr, respValid, occupancy);
        end
        pulse_t0();
        pulse_resp(36'h5A5A5A5A5);
        checks++;
        if (respValid !== 1'b1 || respData !== 36'h5A5A5A5A5 || retryErr !== 1'b0) begin
            failures++;
            $display("FAIL retry_resp: rv=%b data=%0h err=%b required 1 5a5a5a5a5 0", respValid, respData, retryErr);
        end
        tick();
        tick();
        checks++;
        if (respValid !== 1'b0 || mboxReq !== 1'b0 || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL retry_done: rv=%b req=%b occ=%0d required 0 0 0", respValid, mboxReq, occupancy);
        end
    endtask

    task automatic test_abort();
        bit ok;
        do_reset();
        push(23'h300, 2'b00, 36'h0);
        push(23'h301, 2'b10, 36'h77);
        wait_req(ok);
        for (int k = 1; k <= 8; k++) begin
            pulse_t0();
            pulse_retry();
            checks++;
            if (k < 8) begin
                if (mboxReq !== 1'b1 || retryErr !== 1'b0 || mboxVMA !== 23'h300) begin
                    failures++;
                    $display("FAIL abort_retry%0d: req=%b err=%b vma=%0h required 1 0 300", k, mboxReq, retryErr, mboxVMA);
                end
            end else if (retryErr !== 1'b1 || respValid !== 1'b0 || occupancy !== 3'd1 || mboxVMA !== 23'h301 || mboxReq !== 1'b0) begin
                failures++;
                $display("FAIL abort_pulse: err=%b rv=%b occ=%0d vma=%0h req=%b required 1 0 1 301 0", retryErr, respValid, occupancy, mboxVMA, mboxReq);
            end
        end
        tick();
        checks++;
        if (retryErr !== 1'b0 || mboxReq !== 1'b1) begin
            failures++;
            $display("FAIL abort_next_issue: err=%b req=%b required 0 1", retryErr, mboxReq);
        end
        for (int k = 1; k <= 7; k++) begin
            pulse_t0();
            pulse_retry();
            checks++;
            if (retryErr !== 1'b0 || mboxReq !== 1'b1) begin
                failures++;
                $display("FAIL abort_cnt_reload%0d: err=%b req=%b required 0 1", k, retryErr, mboxReq);
            end
        end
        pulse_t0();
        pulse_resp(36'h0ABCDE);
        checks++;
        if (respValid !== 1'b1 || retryErr !== 1'b0 || respOp !== 2'b10 || respData !== 36'h0ABCDE || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL abort_second_resp: rv=%b err=%b op=%0d data=%0h occ=%0d required 1 0 2 abcde 0", respValid, retryErr, respOp, respData, occupancy);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        push(23'h400, 2'b00, 36'h0);
        wait_req(ok);
        pulse_t0();
        mboxRetry = 1'b1;
        pulse_resp(36'h444);
        mboxRetry = 1'b0;
        checks++;
        if (respValid !== 1'b1 || retryErr !== 1'b0 || occupancy !== 3'd0 || mboxReq !== 1'b0 || respData !== 36'h444) begin
            failures++;
            $display("FAIL simul_resp_wins: rv=%b err=%b occ=%0d req=%b data=%0h required 1 0 0 0 444", respValid, retryErr, occupancy, mboxReq, respData);
        end
        tick();
        checks++;
        if (mboxReq !== 1'b0 || respValid !== 1'b0) begin
            failures++;
            $display("FAIL simul_no_reissue: req=%b rv=%b required 0 0", mboxReq, respValid);
        end
        for (int i = 0; i < 3; i++) push(23'h500 + 23'(i), 2'b00, 36'h0);
        wait_req(ok);
        pulse_t0();
        reqValid = 1'b1; reqVMA = 23'h503; reqOp = 2'b00;
        pulse_resp(36'h555);
        reqValid = 1'b0;
        checks++;
        if (occupancy !== 3'd3 || respValid !== 1'b1 || mboxVMA !== 23'h501) begin
            failures++;
            $display("FAIL simul_push_pop: occ=%0d rv=%b vma=%0h required 3 1 501", occupancy, respValid, mboxVMA);
        end
        push(23'h504, 2'b00, 36'h0);
        checks++;
        if (occupancy !== 3'd4 || reqReady !== 1'b0) begin
            failures++;
            $display("FAIL simul_refill: occ=%0d rdy=%b required 4 0", occupancy, reqReady);
        end
        pulse_t0();
        reqValid = 1'b1; reqVMA = 23'h5FF;
        pulse_resp(36'h0);
        reqValid = 1'b0;
        checks++;
        if (occupancy !== 3'd3 || mboxVMA !== 23'h502) begin
            failures++;
            $display("FAIL simul_full_pop_push: occ=%0d vma=%0h required 3 502", occupancy, mboxVMA);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) push(23'h600 + 23'(i), 2'b00, 36'h0);
        wait_req(ok);
        pulse_t0();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || mboxReq !== 1'b0 || respValid !== 1'b0 || reqReady !== 1'b1 || mboxVMA !== '0) begin
            failures++;
            $display("FAIL rstmid_state: occ=%0d req=%b rv=%b rdy=%b vma=%0h required 0 0 0 1 0", occupancy, mboxReq, respValid, reqReady, mboxVMA);
        end
        pulse_resp(36'h666);
        checks++;
        if (respValid !== 1'b0 || occupancy !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_late_resp: rv=%b occ=%0d required 0 0", respValid, occupancy);
        end
        tick();
        checks++;
        if (respValid !== 1'b0 || retryErr !== 1'b0 || mboxReq !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet: rv=%b err=%b req=%b required 0 0 0", respValid, retryErr, mboxReq);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fill();
        test_retry();
        test_abort();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
